team_03_wb_master: RTL
======================

TEAM_03_WB_MASTER -- requirements
Module: team_03_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: number of BUS-state cycles without ack before abort (legal range 2..255).
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_we  input  1  1=write, 0=read.
REQ-007 SHALL have port cmd_adr  input  32  byte address.
REQ-008 SHALL have port cmd_dat  input  32  write data.
REQ-009 SHALL have port cmd_sel  input  4  byte lane select.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid & rsp_ready at a rising edge.
REQ-012 SHALL have port rsp_dat  output  32  read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err  output  1  1=transaction timed out.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-015 SHALL have ports wbm_adr_o  output  32, wbm_dat_o  output  32, wbm_sel_o  output  4  Wishbone address/data/select.
REQ-016 SHALL have ports wbm_dat_i  input  32, wbm_ack_i  input  1  Wishbone slave data/ack.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, BUS, RESP; all outputs registered.
REQ-019 SHALL drive cmd_ready=1 only in IDLE.
REQ-020 IDLE: on command accept, SHALL latch cmd_we/adr/dat/sel onto wbm_we_o/adr_o/dat_o/sel_o, assert wbm_cyc_o and wbm_stb_o, clear timeout counter, enter BUS (cyc/stb high the cycle after accept).
REQ-021 BUS: SHALL hold cyc, stb, adr, dat, sel, we stable until exit.
REQ-022 BUS: on edge sampling wbm_ack_i=1, SHALL deassert cyc/stb, capture wbm_dat_i into rsp_dat if read (0 if write), set rsp_err=0, enter RESP with rsp_valid=1.
REQ-023 BUS: counter SHALL increment each cycle without ack; when counter reaches TIMEOUT_CYCLES-1 and ack is low, SHALL deassert cyc/stb, set rsp_err=1, rsp_dat=0, enter RESP.
REQ-024 Ack and timeout on same edge: ack SHALL win (rsp_err=0).
REQ-025 RESP: SHALL hold rsp_valid/rsp_dat/rsp_err until rsp_ready; on handshake SHALL clear rsp_valid and return to IDLE (cmd_ready high next cycle).
REQ-026 wbm_ack_i outside BUS SHALL be ignored; no state change.
REQ-027 cmd_valid outside IDLE SHALL be ignored (not queued).
REQ-028 Back-to-back: minimum 4 cycles per transaction with zero-wait slave and rsp_ready tied high (accept, BUS, RESP, IDLE).
REQ-029 wbm_cyc_o and wbm_stb_o SHALL always be equal; never high outside BUS.
REQ-030 Counter width SHALL be 8 bits; SHALL not wrap within BUS.

Reset
REQ-031 wb_rst_i high SHALL immediately force IDLE, cyc/stb/we=0, adr/dat=0, sel=0, rsp_valid=0, rsp_dat=0, rsp_err=0, busy=0, counter=0; cmd_ready=1 after reset release.
REQ-032 Reset asserted in BUS SHALL drop cyc/stb asynchronously, same cycle, and discard the transaction (no response).

Verification
REQ-033 Write: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave acks 2nd BUS cycle -> wbm bus shows those values, cyc/stb 2 cycles, rsp_valid=1 rsp_err=0 rsp_dat=0.
REQ-034 Read: cmd we=0 adr=0x3000_0008, slave returns 0x1234_5678 with ack -> rsp_dat=0x1234_5678, rsp_err=0.
REQ-035 Timeout: TIMEOUT_CYCLES=4, slave never acks -> cyc/stb high exactly 4 cycles, then rsp_err=1, rsp_dat=0.
REQ-036 Ack on final timeout cycle -> rsp_err=0, read data captured.
REQ-037 rsp_ready held low 5 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0, new cmd_valid ignored; handshake then returns to IDLE.
REQ-038 Reset pulse during BUS -> cyc/stb low same cycle, rsp_valid stays 0, next command executes normally.

Source files
------------

// File: rtl/team_03_wb_master.sv
// team_03_wb_master
// Single-outstanding Wishbone classic master. A command is accepted in IDLE
// and put on the bus. The cycle ends on the slave ack, or it is aborted after
// TIMEOUT_CYCLES bus cycles with no ack. The result is then held on the
// response port until it is consumed.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_we/adr/dat/sel            command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat, rsp_err              read data (0 for writes/errors), timeout flag
//   wbm_cyc_o..wbm_sel_o          Wishbone master outputs
//   wbm_dat_i, wbm_ack_i          Wishbone slave inputs
//   busy                          high whenever not in IDLE
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// BUS     | cyc/stb asserted, waiting for ack or timeout
// RESP    | rsp_valid high, waiting for rsp_ready
module team_03_wb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Last counter value before abort; the counter starts at 0 on the first
   // bus cycle, so the bus is held for exactly TIMEOUT_CYCLES cycles.
   localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic        rsp_err_q, rsp_err_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= 32'd0;
         dat_q       <= 32'd0;
         sel_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= 32'd0;
         rsp_err_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               adr_d   = cmd_adr;
               dat_d   = cmd_dat;
               sel_d   = cmd_sel;
               cyc_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
               state_d     = ST_RESP;
            end else if (cnt_q == TC_LAST) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = 32'd0;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   // cyc and stb share one register so they can never differ.
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = we_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;

endmodule
